branch_ctrl: RTL and testbench

Branch hazard controller for the pipelined MIPS-lite core. It sequences the ID-stage branch comparator for BEQ/BNE: it detects operand dependencies on in-flight instructions, stalls the front end until operands are available, and selects MEM-stage forwarding for the comparator operands. On evaluation it drives the PC-select and IF/ID flush. It also keeps saturating branch performance counters. It sits beside the hazard/forwarding logic in the ID stage and consumes the comparator's `zero` (condition-true) output.

---
 rtl/mips_ctrl_pkg.sv | 17 +
 rtl/branch_ctrl_if.sv | 46 ++++
 rtl/sat_counter.sv | 35 +++
 rtl/branch_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants and types for the MIPS-lite control blocks.
//   OP_BEQ / OP_BNE : branch opcodes recognised in ID
//   REG_W           : register-specifier width
//   state_t         : branch controller FSM states (IDLE, STALL, EVAL)
package mips_ctrl_pkg;

  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam int         REG_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_EVAL  = 2'd2
  } state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: ID/EX/MEM hazard inputs and branch decision outputs of the
// branch hazard controller.
//   slave  : the controller (consumes pipeline state, drives decisions)
//   master : the pipeline side (drives pipeline state, consumes decisions)
// Handshake: there is no valid/ready pair here. br_eval is a one-cycle strobe
// meaning "comparator operands are valid and the decision is taken this
// cycle"; stall holds PC and IF/ID in the same cycle it is asserted, and
// pc_sel/flush act at the edge that ends a br_eval cycle.
interface branch_ctrl_if #(
  parameter int REG_W = mips_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
);
  logic [5:0]       id_op;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [REG_W-1:0] mem_rd;
  logic             mem_regwrite;
  logic             mem_memread;
  logic             br_cond;
  logic             br_eval;
  logic             stall;
  logic             flush;
  logic             pc_sel;
  logic             fwd_a;
  logic             fwd_b;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_stall;

  modport slave (
    input  id_op, id_rs, id_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_memread, br_cond,
    output br_eval, stall, flush, pc_sel, fwd_a, fwd_b,
           cnt_branch, cnt_taken, cnt_stall
  );

  modport master (
    output id_op, id_rs, id_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_memread, br_cond,
    input  br_eval, stall, flush, pc_sel, fwd_a, fwd_b,
           cnt_branch, cnt_taken, cnt_stall
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter.
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : count enable for this cycle
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch hazard controller for BEQ/BNE.
//   clk, reset  : clock and synchronous active-high reset
//   bus (slave) : ID/EX/MEM hazard inputs, comparator result, decision
//                 outputs (stall, br_eval, pc_sel, flush, fwd_a/b) and the
//                 saturating branch / taken / stall performance counters
//   dbg_state_o : current FSM state, for observation only
// The required stall count n (0..2) is computed while IDLE; stall, br_eval,
// pc_sel and flush are Mealy outputs so a stall lands in the detection cycle.
module branch_ctrl #(
  parameter logic [5:0] OP_BEQ = mips_ctrl_pkg::OP_BEQ,
  parameter logic [5:0] OP_BNE = mips_ctrl_pkg::OP_BNE,
  parameter int         REG_W  = mips_ctrl_pkg::REG_W,
  parameter int         CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_ctrl_if.slave          bus,
  output mips_ctrl_pkg::state_t dbg_state_o
);
  import mips_ctrl_pkg::state_t;
  import mips_ctrl_pkg::ST_IDLE;
  import mips_ctrl_pkg::ST_STALL;
  import mips_ctrl_pkg::ST_EVAL;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;    // stall cycles still to go after the current one

  logic       is_br;
  logic       ex_dep, mem_dep;
  logic       ex_load, ex_alu, mem_load;
  logic [1:0] need;
  logic       stall_w, eval_w;

  // r0 is hard-wired to zero, so it can never carry a dependency.
  function automatic logic dep_on(input logic [REG_W-1:0] r,
                                  input logic [REG_W-1:0] rs,
                                  input logic [REG_W-1:0] rt);
    return (r != '0) && ((r == rs) || (r == rt));
  endfunction

  assign is_br    = (bus.id_op == OP_BEQ) || (bus.id_op == OP_BNE);
  assign ex_dep   = dep_on(bus.ex_rd, bus.id_rs, bus.id_rt);
  assign mem_dep  = dep_on(bus.mem_rd, bus.id_rs, bus.id_rt);
  assign ex_load  = bus.ex_regwrite && bus.ex_memread;
  assign ex_alu   = bus.ex_regwrite && !bus.ex_memread;
  assign mem_load = bus.mem_regwrite && bus.mem_memread;

  // Max over both operands: a load in EX dominates anything else. A MEM ALU
  // producer is covered by forwarding, WB by the write-first register file.
  always_comb begin
    need = 2'd0;
    if (ex_load && ex_dep) begin
      need = 2'd2;
    end else if ((ex_alu && ex_dep) || (mem_load && mem_dep)) begin
      need = 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; hazard inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (is_br && (need != 2'd0)) begin
          // The detection cycle is already stall cycle 1.
          cnt_d   = need - 2'd1;
          state_d = (need == 2'd1) ? ST_EVAL : ST_STALL;
        end
      end
      ST_STALL: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Output logic (Mealy), forced quiet while reset is held.
  always_comb begin
    stall_w = 1'b0;
    eval_w  = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (is_br) begin
            if (need == 2'd0) begin
              eval_w = 1'b1;
            end else begin
              stall_w = 1'b1;
            end
          end
        end
        ST_STALL: stall_w = 1'b1;
        ST_EVAL:  eval_w  = 1'b1;
        default:  stall_w = 1'b0;
      endcase
    end
  end

  assign bus.stall   = stall_w;
  assign bus.br_eval = eval_w;
  assign bus.pc_sel  = eval_w && bus.br_cond;
  assign bus.flush   = eval_w && bus.br_cond;

  // Only an ALU result sitting in MEM is forwardable to the ID comparator.
  assign bus.fwd_a = !reset && bus.mem_regwrite && !bus.mem_memread &&
                     (bus.mem_rd != '0) && (bus.mem_rd == bus.id_rs);
  assign bus.fwd_b = !reset && bus.mem_regwrite && !bus.mem_memread &&
                     (bus.mem_rd != '0) && (bus.mem_rd == bus.id_rt);

  assign dbg_state_o = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_branch (
    .clk   (clk),
    .reset (reset),
    .inc   (eval_w),
    .count (bus.cnt_branch)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .reset (reset),
    .inc   (eval_w && bus.br_cond),
    .count (bus.cnt_taken)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_w),
    .count (bus.cnt_stall)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed scenarios plus randomized cycles for branch_ctrl,
// checked every cycle against a behavioural model of the branch rules.
module tb_branch_ctrl;

  localparam int         REG_W   = 5;
  localparam int         CNT_W   = 16;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [5:0] BEQ     = 6'd4;
  localparam logic [5:0] BNE     = 6'd5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  mips_ctrl_pkg::state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  branch_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];   // {stall, br_eval, pc_sel, flush, fwd_a, fwd_b}

  // Model state: a branch waiting out its stalls, and expected counters.
  bit m_busy     = 1'b0;
  int m_left     = 0;
  int m_cnt_br   = 0;
  int m_cnt_tk   = 0;
  int m_cnt_st   = 0;

  // Outputs observed in the last ticked cycle, for directed checks.
  logic obs_stall, obs_eval, obs_pc, obs_flush, obs_fa, obs_fb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stall cycles operand r needs before the comparator can use it.
  function automatic int op_need(input logic [REG_W-1:0] r);
    int n = 0;
    if (r == 0) return 0;
    if (bus.ex_regwrite && bus.ex_rd == r) n = bus.ex_memread ? 2 : 1;
    if (bus.mem_regwrite && bus.mem_memread && bus.mem_rd == r && n < 1) n = 1;
    return n;
  endfunction

  function automatic bit op_fwd(input logic [REG_W-1:0] r);
    return (r != 0) && bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd == r);
  endfunction

  function automatic int sat_inc(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [5:0] op, input int rs, input int rt,
                        input int exrd, input bit exrw, input bit exmr,
                        input int memrd, input bit memrw, input bit memmr,
                        input bit cond);
    bus.id_op        = op;
    bus.id_rs        = REG_W'(rs);
    bus.id_rt        = REG_W'(rt);
    bus.ex_rd        = REG_W'(exrd);
    bus.ex_regwrite  = exrw;
    bus.ex_memread   = exmr;
    bus.mem_rd       = REG_W'(memrd);
    bus.mem_regwrite = memrw;
    bus.mem_memread  = memmr;
    bus.br_cond      = cond;
  endtask

  // One clock cycle: predict, compare at the falling edge, then advance.
  task automatic tick();
    bit e_stall, e_eval, e_pc, e_fa, e_fb;
    int n;
    logic [5:0] exp_v;
    @(negedge clk);
    e_stall = 1'b0;
    e_eval  = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_left = 0;
    end else if (m_busy) begin
      if (m_left > 0) begin
        e_stall = 1'b1;
        m_left--;
      end else begin
        e_eval = 1'b1;
        m_busy = 1'b0;
      end
    end else if (bus.id_op == BEQ || bus.id_op == BNE) begin
      n = op_need(bus.id_rs);
      if (op_need(bus.id_rt) > n) n = op_need(bus.id_rt);
      if (n == 0) begin
        e_eval = 1'b1;
      end else begin
        e_stall = 1'b1;
        m_left  = n - 1;
        m_busy  = 1'b1;
      end
    end
    e_pc = e_eval && bus.br_cond;
    e_fa = !reset && op_fwd(bus.id_rs);
    e_fb = !reset && op_fwd(bus.id_rt);
    exp_q.push_back({e_stall, e_eval, e_pc, e_pc, e_fa, e_fb});

    obs_stall = bus.stall;
    obs_eval  = bus.br_eval;
    obs_pc    = bus.pc_sel;
    obs_flush = bus.flush;
    obs_fa    = bus.fwd_a;
    obs_fb    = bus.fwd_b;

    exp_v = exp_q.pop_front();
    check("stall",   32'(obs_stall), 32'(exp_v[5]));
    check("br_eval", 32'(obs_eval),  32'(exp_v[4]));
    check("pc_sel",  32'(obs_pc),    32'(exp_v[3]));
    check("flush",   32'(obs_flush), 32'(exp_v[2]));
    check("fwd_a",   32'(obs_fa),    32'(exp_v[1]));
    check("fwd_b",   32'(obs_fb),    32'(exp_v[0]));
    check("cnt_branch", 32'(bus.cnt_branch), 32'(m_cnt_br));
    check("cnt_taken",  32'(bus.cnt_taken),  32'(m_cnt_tk));
    check("cnt_stall",  32'(bus.cnt_stall),  32'(m_cnt_st));

    if (reset) begin
      m_cnt_br = 0;
      m_cnt_tk = 0;
      m_cnt_st = 0;
    end else begin
      if (e_eval)               m_cnt_br = sat_inc(m_cnt_br);
      if (e_eval && bus.br_cond) m_cnt_tk = sat_inc(m_cnt_tk);
      if (e_stall)              m_cnt_st = sat_inc(m_cnt_st);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    set_in(6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    check("rst_cnt_branch", 32'(bus.cnt_branch), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(mips_ctrl_pkg::ST_IDLE));

    // Taken BEQ with no producers: decided in the ID cycle itself.
    set_in(BEQ, 3, 4, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("t1_stall", 32'(obs_stall), 32'd0);
    check("t1_eval",  32'(obs_eval),  32'd1);
    check("t1_pcsel", 32'(obs_pc),    32'd1);
    check("t1_flush", 32'(obs_flush), 32'd1);
    check("t1_cnt_branch", 32'(bus.cnt_branch), 32'd1);
    check("t1_cnt_taken",  32'(bus.cnt_taken),  32'd1);

    // Load in EX writes r5, BNE reads r5: two stalls, no forwarding.
    do_reset();
    set_in(BNE, 5, 6, 5, 1, 1, 0, 0, 0, 0);
    tick();
    check("t2_stall1", 32'(obs_stall), 32'd1);
    check("t2_state",  32'(dbg_state), 32'(mips_ctrl_pkg::ST_STALL));
    set_in(BNE, 5, 6, 0, 0, 0, 5, 1, 1, 0);
    tick();
    check("t2_stall2", 32'(obs_stall), 32'd1);
    set_in(BNE, 5, 6, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("t2_eval",  32'(obs_eval),  32'd1);
    check("t2_stall", 32'(obs_stall), 32'd0);
    check("t2_fwd_a", 32'(obs_fa),    32'd0);
    check("t2_cnt_stall", 32'(bus.cnt_stall), 32'd2);

    // ALU in EX writes r7, BEQ rt=7 not taken: one stall, then forward b.
    do_reset();
    set_in(BEQ, 1, 7, 7, 1, 0, 0, 0, 0, 0);
    tick();
    check("t3_stall1", 32'(obs_stall), 32'd1);
    check("t3_state",  32'(dbg_state), 32'(mips_ctrl_pkg::ST_EVAL));
    set_in(BEQ, 1, 7, 0, 0, 0, 7, 1, 0, 0);
    tick();
    check("t3_eval",  32'(obs_eval),  32'd1);
    check("t3_fwd_b", 32'(obs_fb),    32'd1);
    check("t3_pcsel", 32'(obs_pc),    32'd0);
    check("t3_flush", 32'(obs_flush), 32'd0);
    check("t3_cnt_stall", 32'(bus.cnt_stall), 32'd1);

    // EX load on r2 and MEM ALU on r9: the larger need (2) applies.
    do_reset();
    set_in(BEQ, 9, 2, 2, 1, 1, 9, 1, 0, 1);
    tick();
    check("t4_stall1", 32'(obs_stall), 32'd1);
    set_in(BEQ, 9, 2, 0, 0, 0, 2, 1, 1, 1);
    tick();
    check("t4_stall2", 32'(obs_stall), 32'd1);
    set_in(BEQ, 9, 2, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("t4_eval",  32'(obs_eval), 32'd1);
    check("t4_fwd_a", 32'(obs_fa),   32'd0);
    check("t4_fwd_b", 32'(obs_fb),   32'd0);
    check("t4_cnt_stall", 32'(bus.cnt_stall), 32'd2);

    // r0 never creates a hazard.
    do_reset();
    set_in(BEQ, 0, 4, 0, 1, 1, 0, 1, 0, 0);
    tick();
    check("t5_stall", 32'(obs_stall), 32'd0);
    check("t5_eval",  32'(obs_eval),  32'd1);
    check("t5_fwd_a", 32'(obs_fa),    32'd0);

    // Reset while stalled abandons the branch.
    do_reset();
    set_in(BEQ, 3, 3, 3, 1, 1, 0, 0, 0, 1);
    tick();
    check("t6_stall1", 32'(obs_stall), 32'd1);
    set_in(BEQ, 3, 3, 0, 0, 0, 3, 1, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_stall", 32'(obs_stall), 32'd0);
    check("t6_rst_eval",  32'(obs_eval),  32'd0);
    check("t6_rst_fwd_a", 32'(obs_fa),    32'd0);
    check("t6_state", 32'(dbg_state), 32'(mips_ctrl_pkg::ST_IDLE));
    check("t6_cnt_stall",  32'(bus.cnt_stall),  32'd0);
    check("t6_cnt_branch", 32'(bus.cnt_branch), 32'd0);
    idle_in();
    tick();
    check("t6_idle_eval", 32'(obs_eval), 32'd0);

    // Randomized cycles against the model.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [5:0] op;
      bit exrw, memrw;
      sel = $urandom_range(0, 3);
      op  = (sel == 0) ? BEQ : (sel == 1) ? BNE : (sel == 2) ? 6'd0 : 6'd35;
      exrw  = 1'($urandom_range(0, 1));
      memrw = 1'($urandom_range(0, 1));
      set_in(op, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), exrw, exrw & 1'($urandom_range(0, 1)),
             $urandom_range(0, 7), memrw, memrw & 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0;

    // Drive counters into saturation with back-to-back taken branches.
    do_reset();
    set_in(BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < CNT_MAX + 2; i++) tick();
    check("sat_branch", 32'(bus.cnt_branch), 32'hFFFF);
    check("sat_taken",  32'(bus.cnt_taken),  32'hFFFF);
    tick();
    check("sat_branch_hold", 32'(bus.cnt_branch), 32'hFFFF);
    check("sat_taken_hold",  32'(bus.cnt_taken),  32'hFFFF);
    check("sat_stall_zero",  32'(bus.cnt_stall),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
